// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Single-port memory controller and arbiter. It shares one byte-wide RAM
// between instruction fetch (IF) and load/store (MEM). Each 32-bit fetch or
// 1/2/4-byte load/store is broken into one RAM cycle per byte. The assembled
// data is returned with a one-cycle done pulse. MEM has fixed priority over IF,
// and an IF read that is pending or in flight can be cancelled by a branch
// redirect.
//
// Ports
//   clk_in, rst_in        clock, synchronous active-high reset
//   if_req/if_addr        fetch request (always 4 bytes), held until if_done
//   if_cancel             abort a pending or in-flight fetch
//   if_done/if_data       one-cycle completion pulse and fetched word (LE)
//   mem_req/mem_we        load/store request (held until mem_done), 1 = store
//   mem_addr/mem_len      byte address and byte count (1, 2, else 4)
//   mem_wdata             store data, low mem_len bytes used
//   mem_done/mem_rdata    one-cycle completion pulse and zero-extended load data
//   ram_a/ram_wr/ram_dout RAM address, write enable and write byte
//   ram_din               RAM read byte, valid the cycle after its address
//   if_stall/mem_stall    requester-waiting lines to the stall controller
// -----------------------------------------------------------------------------
module mem_arbiter (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_cancel,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [2:0]  mem_len,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    output logic        if_stall,
    output logic        mem_stall
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    // Any byte count other than 1 or 2 is handled as a full word.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        case (len)
            3'd1:    norm_len = 3'd1;
            3'd2:    norm_len = 3'd2;
            default: norm_len = 3'd4;
        endcase
    endfunction

    // Transaction state
    logic [1:0]  state_q,     state_d;
    logic        owner_q,     owner_d;
    logic [31:0] base_q,      base_d;
    logic [2:0]  len_q,       len_d;
    logic [31:0] wdata_q,     wdata_d;
    logic [2:0]  cnt_q,       cnt_d;      // bytes issued to the RAM
    logic [2:0]  cap_q,       cap_d;      // bytes captured from the RAM

    // Read pipeline tracking: iss1 = an address is on ram_a this cycle,
    // iss2 = the byte for the previous address is on ram_din this cycle.
    logic        iss1_q,      iss1_d;
    logic        iss2_q,      iss2_d;

    // Registered outputs
    logic [31:0] ram_a_q,     ram_a_d;
    logic        ram_wr_q,    ram_wr_d;
    logic [7:0]  ram_dout_q,  ram_dout_d;
    logic [31:0] if_data_q,   if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_done_q,   if_done_d;
    logic        mem_done_q,  mem_done_d;

    // Lane buffer control
    logic        buf_clr;     // clear all lanes at the start of a transaction
    logic        buf_cap;     // capture ram_din into lane cap_q
    logic [31:0] word_asm;    // lanes with this cycle's capture already merged

    // -------------------------------------------------------------------------
    // Lane buffer: one byte register per lane. word_asm forwards the byte being
    // captured this cycle so the final byte lands in the output word on the
    // same edge that enters DONE.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_q;
        logic       hit;

        assign hit = buf_cap && (cap_q[1:0] == 2'(gi));

        always_ff @(posedge clk_in) begin
            if (rst_in || buf_clr) begin
                lane_q <= '0;
            end else if (hit) begin
                lane_q <= ram_din;
            end
        end

        assign word_asm[8*gi +: 8] = hit ? ram_din : lane_q;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        base_d      = base_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        iss1_d      = 1'b0;
        iss2_d      = 1'b0;
        ram_a_d     = ram_a_q;
        ram_wr_d    = 1'b0;
        ram_dout_d  = ram_dout_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        buf_clr     = 1'b0;
        buf_cap     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The first byte is issued on the grant edge, so the first
                // address appears in the cycle after the request is seen.
                if (mem_req) begin
                    owner_d = OWN_MEM;
                    base_d  = mem_addr;
                    len_d   = norm_len(mem_len);
                    wdata_d = mem_wdata;
                    cnt_d   = 3'd1;
                    cap_d   = 3'd0;
                    ram_a_d = mem_addr;
                    buf_clr = 1'b1;
                    if (mem_we) begin
                        state_d    = ST_WRITE;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata[7:0];
                    end else begin
                        state_d = ST_READ;
                        iss1_d  = 1'b1;
                    end
                end else if (if_req && !if_cancel) begin
                    owner_d = OWN_IF;
                    base_d  = if_addr;
                    len_d   = 3'd4;
                    cnt_d   = 3'd1;
                    cap_d   = 3'd0;
                    ram_a_d = if_addr;
                    buf_clr = 1'b1;
                    state_d = ST_READ;
                    iss1_d  = 1'b1;
                end
            end

            ST_READ: begin
                if (owner_q == OWN_IF && if_cancel) begin
                    // Redirect: abandon the fetch; any byte still in flight
                    // from the RAM is ignored because iss1/iss2 clear.
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                    cap_d   = 3'd0;
                end else begin
                    iss2_d = iss1_q;
                    if (cnt_q < len_q) begin
                        ram_a_d = base_q + {29'd0, cnt_q};
                        cnt_d   = cnt_q + 3'd1;
                        iss1_d  = 1'b1;
                    end
                    if (iss2_q) begin
                        buf_cap = 1'b1;
                        cap_d   = cap_q + 3'd1;
                        if (cap_q == len_q - 3'd1) begin
                            state_d = ST_DONE;
                            if (owner_q == OWN_IF) begin
                                if_done_d = 1'b1;
                                if_data_d = word_asm;
                            end else begin
                                mem_done_d  = 1'b1;
                                mem_rdata_d = word_asm;
                            end
                        end
                    end
                end
            end

            ST_WRITE: begin
                if (cnt_q < len_q) begin
                    ram_a_d    = base_q + {29'd0, cnt_q};
                    ram_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    ram_wr_d   = 1'b1;
                    cnt_d      = cnt_q + 3'd1;
                end else begin
                    // The last byte was written in this cycle.
                    state_d    = ST_DONE;
                    mem_done_d = 1'b1;
                end
            end

            ST_DONE: begin
                // Requests are ignored here; the requester drops or changes
                // its request while we return to IDLE.
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
                cap_d   = 3'd0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            base_q      <= '0;
            len_q       <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cap_q       <= '0;
            iss1_q      <= 1'b0;
            iss2_q      <= 1'b0;
            ram_a_q     <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            base_q      <= base_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            iss1_q      <= iss1_d;
            iss2_q      <= iss2_d;
            ram_a_q     <= ram_a_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // A cancel arriving in the DONE cycle still suppresses the fetch pulse,
    // so the gating has to be combinational on top of the registered pulse.
    assign if_done   = if_done_q && !if_cancel;
    assign mem_done  = mem_done_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;
    assign ram_a     = ram_a_q;
    assign ram_wr    = ram_wr_q;
    assign ram_dout  = ram_dout_q;

    assign if_stall  = !rst_in && if_req  && !if_done;
    assign mem_stall = !rst_in && mem_req && !mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed cycle-accurate scenarios followed by two concurrent randomized
// requesters (IF with random cancels, MEM with random loads/stores). Expected
// responses are pushed into queues when stimulus is issued; a monitor pops
// and compares on every done pulse and RAM write.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_cancel = 1'b0;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [2:0]  mem_len = 3'd4;
    logic [31:0] mem_wdata = '0;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = '0;
    logic        if_stall;
    logic        mem_stall;

    int checks   = 0;
    int failures = 0;

    mem_arbiter dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_cancel (if_cancel),
        .if_done   (if_done),
        .if_data   (if_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_len   (mem_len),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .ram_a     (ram_a),
        .ram_wr    (ram_wr),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din),
        .if_stall  (if_stall),
        .mem_stall (mem_stall)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- RAM contents (64 KiB, aliased on the low 16 bits) -----
    function automatic logic [7:0] init_byte(input logic [15:0] a);
        case (a)
            16'h0100: init_byte = 8'h13;
            16'h0101: init_byte = 8'h05;
            16'h0102: init_byte = 8'h10;
            16'h0103: init_byte = 8'h00;
            16'h0200: init_byte = 8'hFF;
            16'h0201: init_byte = 8'h80;
            default:  init_byte = a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
        endcase
    endfunction

    // Physical RAM seen by the DUT: registered read, one-cycle latency.
    bit [7:0] ram_arr [65536];
    bit       ram_wv  [65536];

    always @(posedge clk_in) begin
        ram_din <= ram_wv[ram_a[15:0]] ? ram_arr[ram_a[15:0]] : init_byte(ram_a[15:0]);
        if (ram_wr) begin
            ram_arr[ram_a[15:0]] <= ram_dout;
            ram_wv[ram_a[15:0]]  <= 1'b1;
        end
    end

    // ---------------- Reference model --------------------------------------
    logic [7:0] ref_mem [65536];

    function automatic int len_bytes(input logic [2:0] len);
        if (len == 3'd1) return 1;
        if (len == 3'd2) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] w;
        logic [31:0] ai;
        w = '0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            w[8*i +: 8] = ref_mem[ai[15:0]];
        end
        return w;
    endfunction

    // Scoreboard queues
    logic [31:0] if_exp  [$];
    logic [32:0] mem_exp [$];   // bit 32: compare data (loads only)
    logic [39:0] wr_exp  [$];   // {address, byte}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_write_byte(input logic [31:0] a, input logic [7:0] b);
        wr_exp.push_back({a, b});
        ref_mem[a[15:0]] = b;
    endtask

    task automatic exp_mem(input logic we, input logic [31:0] a, input logic [2:0] len,
                           input logic [31:0] wd);
        int n;
        n = len_bytes(len);
        if (we) begin
            for (int i = 0; i < n; i++) exp_write_byte(a + 32'(i), wd[8*i +: 8]);
            mem_exp.push_back({1'b0, 32'h0});
        end else begin
            mem_exp.push_back({1'b1, ref_word(a, n)});
        end
    endtask

    task automatic exp_if(input logic [31:0] a);
        if_exp.push_back(ref_word(a, 4));
    endtask

    // ---------------- Monitor ----------------------------------------------
    logic [31:0] mon_ie;
    logic [32:0] mon_me;
    logic [39:0] mon_we;

    always @(negedge clk_in) begin
        if (if_done) begin
            if (if_exp.size() == 0) chk("unexpected if_done", 32'd1, 32'd0);
            else begin
                mon_ie = if_exp.pop_front();
                chk("if_data", if_data, mon_ie);
            end
        end
        if (mem_done) begin
            if (mem_exp.size() == 0) chk("unexpected mem_done", 32'd1, 32'd0);
            else begin
                mon_me = mem_exp.pop_front();
                if (mon_me[32]) chk("mem_rdata", mem_rdata, mon_me[31:0]);
            end
        end
        if (ram_wr) begin
            if (wr_exp.size() == 0) chk("unexpected ram_wr", ram_a, 32'hFFFF_FFFF);
            else begin
                mon_we = wr_exp.pop_front();
                chk("ram_wr addr", ram_a, mon_we[39:8]);
                chk("ram_wr byte", {24'd0, ram_dout}, {24'd0, mon_we[7:0]});
            end
        end
    end

    // ---------------- Random requesters ------------------------------------
    task automatic if_txn(input logic [31:0] a, input int cancel_at);
        if_addr = a;
        if_req  = 1'b1;
        exp_if(a);
        for (int k = 0; k < 400; k++) begin
            if (k == cancel_at) begin
                if_cancel = 1'b1;
                if_req    = 1'b0;
                void'(if_exp.pop_back());
                @(posedge clk_in); #1;
                if_cancel = 1'b0;
                return;
            end
            @(negedge clk_in);
            if (if_done) begin
                @(posedge clk_in); #1;
                if_req = 1'b0;
                return;
            end
            @(posedge clk_in); #1;
        end
        chk("if_done timeout", 32'd0, 32'd1);
        if_req = 1'b0;
        void'(if_exp.pop_back());
    endtask

    task automatic mem_txn(input logic we, input logic [31:0] a, input logic [2:0] len,
                           input logic [31:0] wd);
        mem_we    = we;
        mem_addr  = a;
        mem_len   = len;
        mem_wdata = wd;
        mem_req   = 1'b1;
        exp_mem(we, a, len, wd);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk_in);
            if (mem_done) begin
                @(posedge clk_in); #1;
                mem_req = 1'b0;
                return;
            end
            @(posedge clk_in); #1;
        end
        chk("mem_done timeout", 32'd0, 32'd1);
        mem_req = 1'b0;
    endtask

    // ---------------- Main sequence ----------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base;
        logic [31:0] wd;

        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));

        // Reset: every output low
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_in); #1;
            @(negedge clk_in);
            chk("rst ram_a", ram_a, 32'd0);
            chk("rst ram_wr/done", {29'd0, ram_wr, if_done, mem_done}, 32'd0);
            chk("rst if_data", if_data, 32'd0);
            chk("rst mem_rdata", mem_rdata, 32'd0);
        end
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // 1: IF fetch at 0x100
        exp_if(32'h100);
        for (int c = 0; c <= 7; c++) begin
            @(posedge clk_in); #1;
            if (c == 0) begin if_req = 1'b1; if_addr = 32'h100; end
            if (c == 7) if_req = 1'b0;
            @(negedge clk_in);
            if (c <= 7) chk($sformatf("t1 if_stall c%0d", c), {31'd0, if_stall}, {31'd0, c <= 5});
            chk($sformatf("t1 if_done c%0d", c), {31'd0, if_done}, {31'd0, c == 6});
            if (c >= 1 && c <= 4) chk($sformatf("t1 ram_a c%0d", c), ram_a, 32'h100 + 32'(c - 1));
            if (c == 5 || c == 6) chk($sformatf("t1 ram_a hold c%0d", c), ram_a, 32'h103);
            if (c == 6) chk("t1 if_data", if_data, 32'h0010_0513);
        end

        // 2: simultaneous requests, MEM wins
        exp_mem(1'b0, 32'h200, 3'd2, 32'h0);
        exp_if(32'h1100);
        for (int c = 0; c <= 12; c++) begin
            @(posedge clk_in); #1;
            if (c == 0) begin
                if_req = 1'b1; if_addr = 32'h1100;
                mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_len = 3'd2;
            end
            if (c == 5)  mem_req = 1'b0;
            if (c == 12) if_req = 1'b0;
            @(negedge clk_in);
            chk($sformatf("t2 mem_done c%0d", c), {31'd0, mem_done}, {31'd0, c == 4});
            chk($sformatf("t2 if_done c%0d", c), {31'd0, if_done}, {31'd0, c == 11});
            chk($sformatf("t2 mem_stall c%0d", c), {31'd0, mem_stall}, {31'd0, c <= 3});
            chk($sformatf("t2 if_stall c%0d", c), {31'd0, if_stall}, {31'd0, c <= 10});
            if (c == 4) chk("t2 mem_rdata", mem_rdata, 32'h0000_80FF);
            if (c == 6) chk("t2 if grant ram_a", ram_a, 32'h1100);
        end

        // 3: store len 1 at 0x1003
        exp_mem(1'b1, 32'h1003, 3'd1, 32'hAABB_CCDD);
        for (int c = 0; c <= 3; c++) begin
            @(posedge clk_in); #1;
            if (c == 0) begin
                mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h1003;
                mem_len = 3'd1; mem_wdata = 32'hAABB_CCDD;
            end
            if (c == 3) mem_req = 1'b0;
            @(negedge clk_in);
            chk($sformatf("t3 ram_wr c%0d", c), {31'd0, ram_wr}, {31'd0, c == 1});
            chk($sformatf("t3 mem_done c%0d", c), {31'd0, mem_done}, {31'd0, c == 2});
            if (c == 1) begin
                chk("t3 ram_a", ram_a, 32'h1003);
                chk("t3 ram_dout", {24'd0, ram_dout}, 32'hDD);
            end
        end

        // 4: store len 4 wrapping past 0xFFFFFFFF
        base = 32'hFFFF_FFFE;
        wd   = 32'hAABB_CCDD;
        exp_mem(1'b1, base, 3'd4, wd);
        for (int c = 0; c <= 6; c++) begin
            @(posedge clk_in); #1;
            if (c == 0) begin
                mem_req = 1'b1; mem_we = 1'b1; mem_addr = base;
                mem_len = 3'd4; mem_wdata = wd;
            end
            if (c == 6) mem_req = 1'b0;
            @(negedge clk_in);
            chk($sformatf("t4 ram_wr c%0d", c), {31'd0, ram_wr}, {31'd0, c >= 1 && c <= 4});
            chk($sformatf("t4 mem_done c%0d", c), {31'd0, mem_done}, {31'd0, c == 5});
            if (c >= 1 && c <= 4) begin
                chk($sformatf("t4 ram_a c%0d", c), ram_a, base + 32'(c - 1));
                chk($sformatf("t4 ram_dout c%0d", c), {24'd0, ram_dout}, {24'd0, wd[8*(c-1) +: 8]});
            end
        end

        // 5: fetch cancelled in cycle 3, new fetch granted in cycle 4
        exp_if(32'h1300);
        for (int c = 0; c <= 11; c++) begin
            @(posedge clk_in); #1;
            if (c == 0) begin if_req = 1'b1; if_addr = 32'h1200; end
            if (c == 3) if_cancel = 1'b1;
            if (c == 4) begin if_cancel = 1'b0; if_addr = 32'h1300; end
            if (c == 11) if_req = 1'b0;
            @(negedge clk_in);
            chk($sformatf("t5 if_done c%0d", c), {31'd0, if_done}, {31'd0, c == 10});
            if (c == 5) chk("t5 regrant ram_a", ram_a, 32'h1300);
        end

        // 6: reset during cycle 2 of a 4-byte store
        exp_write_byte(32'h8010, 8'h44);
        exp_write_byte(32'h8011, 8'h33);
        for (int c = 0; c <= 8; c++) begin
            @(posedge clk_in); #1;
            if (c == 0) begin
                mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8010;
                mem_len = 3'd4; mem_wdata = 32'h1122_3344;
            end
            if (c == 2) rst_in = 1'b1;
            if (c == 3) mem_req = 1'b0;
            if (c == 4) rst_in = 1'b0;
            @(negedge clk_in);
            if (c >= 3) begin
                chk($sformatf("t6 ram_wr c%0d", c), {31'd0, ram_wr}, 32'd0);
                chk($sformatf("t6 mem_done c%0d", c), {31'd0, mem_done}, 32'd0);
            end
            if (c == 3) begin
                chk("t6 ram_a", ram_a, 32'd0);
                chk("t6 ram_dout", {24'd0, ram_dout}, 32'd0);
                chk("t6 if_data", if_data, 32'd0);
                chk("t6 mem_rdata", mem_rdata, 32'd0);
                chk("t6 if_done/stalls", {29'd0, if_done, if_stall, mem_stall}, 32'd0);
            end
        end

        // Randomized concurrent traffic
        fork
            begin : if_driver
                logic [31:0] a;
                int          cx;
                for (int t = 0; t < 30; t++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk_in); #1; end
                    a  = {16'($urandom), 16'h1000 + 16'($urandom_range(0, 16'h0FF0))};
                    cx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
                    if_txn(a, cx);
                end
            end
            begin : mem_driver
                logic [31:0] a;
                logic [2:0]  len;
                for (int t = 0; t < 50; t++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk_in); #1; end
                    if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                    else a = {16'($urandom), 16'h8000 + 16'($urandom_range(0, 16'h00F0))};
                    len = 3'($urandom_range(0, 7));
                    mem_txn(1'($urandom), a, len, $urandom);
                end
            end
        join

        repeat (10) begin @(posedge clk_in); #1; end
        chk("if_exp drained", 32'(if_exp.size()), 32'd0);
        chk("mem_exp drained", 32'(mem_exp.size()), 32'd0);
        chk("wr_exp drained", 32'(wr_exp.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
